csr_access_ctrl: RTL

//  Sequences Zicsr read-modify-write accesses onto the CSR unit's single read port and single write port.

---
 rtl/csr_access_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/csr_access_ctrl.sv
// -----------------------------------------------------------------------------
// csr_access_ctrl
//
// Sequences Zicsr read-modify-write accesses from two requesters onto the CSR
// unit's single read port and single write port. Port 0 is the core execute
// stage and port 1 is the debug/host port. Only one transaction is in flight
// at a time: accept -> read -> (optional) write -> respond. The read, the
// modify step and the write therefore look atomic to both requesters.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   reqN_valid_i/ready_o    request handshake (ready is a one-cycle pulse)
//   reqN_op_i               00 read, 01 RW, 10 RS (set), 11 RC (clear)
//   reqN_addr_i/src_i       CSR address and rs1 / zero-extended zimm
//   reqN_srcz_i             source is x0 / zimm==0 (suppresses RS/RC write)
//   rspN_valid_o/ready_i    response handshake
//   rspN_rdata_o/err_o      old CSR value, illegal-access flag
//   csr_raddr_o/rdata_i     CSR unit read port (combinational read data)
//   csr_waddr_o/wdata_o/wr_o CSR unit write port
// -----------------------------------------------------------------------------
module csr_access_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [1:0]        req0_op_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_src_i,
    input  logic              req0_srcz_i,
    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic [DATA_W-1:0] rsp0_rdata_o,
    output logic              rsp0_err_o,

    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [1:0]        req1_op_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_src_i,
    input  logic              req1_srcz_i,
    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [DATA_W-1:0] rsp1_rdata_o,
    output logic              rsp1_err_o,

    output logic [ADDR_W-1:0] csr_raddr_o,
    input  logic [DATA_W-1:0] csr_rdata_i,
    output logic [ADDR_W-1:0] csr_waddr_o,
    output logic [DATA_W-1:0] csr_wdata_o,
    output logic              csr_wr_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state;
    logic              ptr;      // 0: port 0 wins a tie, 1: port 1 wins
    logic              owner;    // port that owns the in-flight transaction
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] src_q;
    logic              srcz_q;
    logic [DATA_W-1:0] old_q;
    logic [DATA_W-1:0] new_q;
    logic              wr_q;
    logic              rsp_vld_q;
    logic              err_q;

    logic              gnt0;
    logic              gnt1;
    logic              ro;
    logic              modifies;
    logic              wen;
    logic              err_c;
    logic              owner_rsp_ready;

    // Zicsr modify step: RW replaces, RS sets bits, RC clears bits.
    function automatic logic [DATA_W-1:0] csr_modify(input logic [1:0]        op,
                                                     input logic [DATA_W-1:0] old,
                                                     input logic [DATA_W-1:0] src);
        logic [DATA_W-1:0] res;
        case (op)
            2'b01:   res = src;
            2'b10:   res = old | src;
            2'b11:   res = old & ~src;
            default: res = old;
        endcase
        return res;
    endfunction

    // Arbitration is only live in IDLE; ready is combinational from valid.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE) begin
            if (req0_valid_i && (!req1_valid_i || !ptr)) begin
                gnt0 = 1'b1;
            end else if (req1_valid_i) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;

    // Top two address bits 11 mark a read-only CSR. A request "modifies"
    // when it is RW, or RS/RC with a non-zero source; such a request is
    // either a legal write or an illegal access, never both.
    assign ro       = (addr_q[ADDR_W-1 -: 2] == 2'b11);
    assign modifies = (op_q == 2'b01) || (op_q[1] && !srcz_q);
    assign wen      = modifies && !ro;
    assign err_c    = modifies && ro;

    assign owner_rsp_ready = owner ? rsp1_ready_i : rsp0_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            owner     <= 1'b0;
            op_q      <= '0;
            addr_q    <= '0;
            src_q     <= '0;
            srcz_q    <= 1'b0;
            old_q     <= '0;
            new_q     <= '0;
            wr_q      <= 1'b0;
            rsp_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        owner  <= gnt1;
                        op_q   <= gnt1 ? req1_op_i   : req0_op_i;
                        addr_q <= gnt1 ? req1_addr_i : req0_addr_i;
                        src_q  <= gnt1 ? req1_src_i  : req0_src_i;
                        srcz_q <= gnt1 ? req1_srcz_i : req0_srcz_i;
                        // Point at the port that was not just served.
                        ptr    <= gnt0;
                        state  <= READ;
                    end
                end
                READ: begin
                    old_q <= csr_rdata_i;
                    new_q <= csr_modify(op_q, csr_rdata_i, src_q);
                    err_q <= err_c;
                    if (wen) begin
                        wr_q  <= 1'b1;
                        state <= WRITE;
                    end else begin
                        rsp_vld_q <= 1'b1;
                        state     <= RESP;
                    end
                end
                WRITE: begin
                    wr_q      <= 1'b0;
                    rsp_vld_q <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (owner_rsp_ready) begin
                        rsp_vld_q <= 1'b0;
                        err_q     <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Addresses hold the last captured value between transactions.
    assign csr_raddr_o  = addr_q;
    assign csr_waddr_o  = addr_q;
    assign csr_wdata_o  = new_q;
    assign csr_wr_o     = wr_q;

    assign rsp0_valid_o = rsp_vld_q && !owner;
    assign rsp1_valid_o = rsp_vld_q && owner;
    assign rsp0_err_o   = err_q && !owner;
    assign rsp1_err_o   = err_q && owner;
    assign rsp0_rdata_o = old_q;
    assign rsp1_rdata_o = old_q;

endmodule
